// File: rtl/adsr_env_pkg.sv
// Shared types and lookup tables for the per-voice ADSR envelope generator.
package apu_env_pkg;

  localparam int RATE_TBL_W = 12;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;

  // Samples per rate tick for each 4-bit rate index.
  function automatic logic [RATE_TBL_W-1:0] rate_period(input logic [3:0] idx);
    logic [RATE_TBL_W-1:0] p;
    case (idx)
      4'd0:    p = 12'd1;
      4'd1:    p = 12'd2;
      4'd2:    p = 12'd4;
      4'd3:    p = 12'd6;
      4'd4:    p = 12'd9;
      4'd5:    p = 12'd14;
      4'd6:    p = 12'd17;
      4'd7:    p = 12'd20;
      4'd8:    p = 12'd25;
      4'd9:    p = 12'd62;
      4'd10:   p = 12'd125;
      4'd11:   p = 12'd200;
      4'd12:   p = 12'd250;
      4'd13:   p = 12'd750;
      4'd14:   p = 12'd1250;
      default: p = 12'd2000;
    endcase
    return p;
  endfunction

  // Piecewise-exponential slowdown: quieter levels need more ticks per step.
  function automatic logic [4:0] exp_div(input logic [7:0] lvl);
    logic [4:0] d;
    if (lvl >= 8'd94)      d = 5'd1;
    else if (lvl >= 8'd54) d = 5'd2;
    else if (lvl >= 8'd26) d = 5'd4;
    else if (lvl >= 8'd14) d = 5'd8;
    else if (lvl >= 8'd6)  d = 5'd16;
    else                   d = 5'd30;
    return d;
  endfunction

endpackage

// File: rtl/adsr_env_if.sv
// Voice-register-file side of one envelope generator: controls in, level/state out.
interface adsr_env_if;
  import apu_env_pkg::*;

  // sample_strobe is a one-clk pulse; controls are only looked at on it and
  // outputs only move on it, so there is no valid/ready back-pressure.
  logic       sample_strobe;
  logic       gate;
  logic [3:0] attack;
  logic [3:0] decay;
  logic [3:0] sustain;
  logic [3:0] release_rate;
  logic [7:0] env_vol;
  env_state_t env_state;
  logic       env_idle;

  modport master (
    output sample_strobe, gate, attack, decay, sustain, release_rate,
    input  env_vol, env_state, env_idle
  );

  modport slave (
    input  sample_strobe, gate, attack, decay, sustain, release_rate,
    output env_vol, env_state, env_idle
  );

endinterface

// File: rtl/adsr_env_rate_div.sv
// Two-stage prescaler: rate period in samples, then exponential divisor in ticks.
module adsr_rate_div #(
  parameter int RATE_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              strobe,
  input  logic              clear,
  input  logic [RATE_W-1:0] period,
  input  logic [4:0]        divisor,
  output logic              step
);

  logic [RATE_W-1:0] rate_cnt;
  logic [4:0]        exp_cnt;
  logic [RATE_W:0]   rate_inc;
  logic [5:0]        exp_inc;
  logic              tick;
  logic              exp_hit;

  assign rate_inc = {1'b0, rate_cnt} + (RATE_W+1)'(1);
  assign exp_inc  = {1'b0, exp_cnt} + 6'd1;

  // >= rather than == so a shortened period mid-count fires at once.
  assign tick    = rate_inc >= {1'b0, period};
  assign exp_hit = exp_inc >= {1'b0, divisor};
  assign step    = strobe & ~clear & tick & exp_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rate_cnt <= '0;
      exp_cnt  <= '0;
    end else if (strobe) begin
      if (clear) begin
        rate_cnt <= '0;
        exp_cnt  <= '0;
      end else if (tick) begin
        rate_cnt <= '0;
        exp_cnt  <= exp_hit ? 5'd0 : exp_inc[4:0];
      end else begin
        rate_cnt <= rate_inc[RATE_W-1:0];
      end
    end
  end

endmodule

// File: rtl/adsr_env.sv
// ADSR envelope FSM and level register; advances once per sample_strobe.
module adsr_env
  import apu_env_pkg::*;
#(
  parameter int RATE_W = 12,
  parameter bit EXP_EN = 1'b1
) (
  input logic        clk,
  input logic        rst_n,
  adsr_env_if.slave  bus
);

  env_state_t        state;
  env_state_t        state_nxt;
  logic [7:0]        vol;
  logic [7:0]        vol_nxt;
  logic              gate_q;
  logic              rise;
  logic              fall;
  logic              clear;
  logic              step;
  logic [7:0]        sus_lvl;
  logic [3:0]        rate_idx;
  logic [4:0]        divisor;
  logic [RATE_W-1:0] period;

  assign sus_lvl = {bus.sustain, bus.sustain};
  assign rise    = bus.gate & ~gate_q;
  assign fall    = ~bus.gate & gate_q;

  always_comb begin
    rate_idx = 4'd0;
    divisor  = 5'd1;
    case (state)
      ATTACK:  rate_idx = bus.attack;
      DECAY: begin
        rate_idx = bus.decay;
        divisor  = EXP_EN ? exp_div(vol) : 5'd1;
      end
      RELEASE: begin
        rate_idx = bus.release_rate;
        divisor  = EXP_EN ? exp_div(vol) : 5'd1;
      end
      default: ;
    endcase
  end

  assign period = RATE_W'(rate_period(rate_idx));

  // Counters restart on gate edges and whenever the envelope is parked.
  always_comb begin
    clear = 1'b0;
    if (rise || fall) begin
      clear = 1'b1;
    end else begin
      case (state)
        IDLE:    clear = 1'b1;
        SUSTAIN: clear = 1'b1;
        DECAY:   clear = (vol <= sus_lvl);
        RELEASE: clear = (vol == 8'h00);
        ATTACK:  clear = 1'b0;
        default: clear = 1'b1;
      endcase
    end
  end

  adsr_rate_div #(.RATE_W(RATE_W)) u_rate_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .strobe  (bus.sample_strobe),
    .clear   (clear),
    .period  (period),
    .divisor (divisor),
    .step    (step)
  );

  always_comb begin
    state_nxt = state;
    vol_nxt   = vol;
    if (rise) begin
      state_nxt = ATTACK;
    end else if (fall) begin
      state_nxt = RELEASE;
    end else begin
      case (state)
        IDLE: vol_nxt = 8'h00;
        ATTACK: begin
          if (step) begin
            if (vol >= 8'hFE) begin
              vol_nxt   = 8'hFF;
              state_nxt = DECAY;
            end else begin
              vol_nxt = vol + 8'd1;
            end
          end
        end
        DECAY: begin
          if (vol <= sus_lvl) begin
            state_nxt = SUSTAIN;
          end else if (step) begin
            vol_nxt = vol - 8'd1;
            if (vol_nxt == sus_lvl) state_nxt = SUSTAIN;
          end
        end
        SUSTAIN: begin
          if (sus_lvl < vol) state_nxt = DECAY;
        end
        RELEASE: begin
          if (vol == 8'h00) begin
            state_nxt = IDLE;
          end else if (step) begin
            vol_nxt = vol - 8'd1;
            if (vol == 8'h01) state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
          vol_nxt   = 8'h00;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      vol    <= 8'h00;
      gate_q <= 1'b0;
    end else if (bus.sample_strobe) begin
      state  <= state_nxt;
      vol    <= vol_nxt;
      gate_q <= bus.gate;
    end
  end

  assign bus.env_vol   = vol;
  assign bus.env_state = state;
  assign bus.env_idle  = (state == IDLE);

endmodule

// File: tb/tb_adsr_env.sv
// Bench for adsr_env: two instances (exponential and linear) against a sample-level model.
module tb_adsr_env;
  import apu_env_pkg::*;

  localparam int S_IDLE = 0;
  localparam int S_ATK  = 1;
  localparam int S_DEC  = 2;
  localparam int S_SUS  = 3;
  localparam int S_REL  = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       sample_strobe = 1'b0;
  logic       gate = 1'b0;
  logic [3:0] attack = 4'd0;
  logic [3:0] decay = 4'd0;
  logic [3:0] sustain = 4'd0;
  logic [3:0] release_rate = 4'd0;

  adsr_env_if e1 ();
  adsr_env_if e0 ();

  assign e1.sample_strobe = sample_strobe;
  assign e1.gate          = gate;
  assign e1.attack        = attack;
  assign e1.decay         = decay;
  assign e1.sustain       = sustain;
  assign e1.release_rate  = release_rate;
  assign e0.sample_strobe = sample_strobe;
  assign e0.gate          = gate;
  assign e0.attack        = attack;
  assign e0.decay         = decay;
  assign e0.sustain       = sustain;
  assign e0.release_rate  = release_rate;

  adsr_env #(.RATE_W(12), .EXP_EN(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(e1.slave));
  adsr_env #(.RATE_W(12), .EXP_EN(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(e0.slave));

  // reference model: index 1 = exponential instance, index 0 = linear instance
  int period_tab[16] = '{1, 2, 4, 6, 9, 14, 17, 20, 25, 62, 125, 200, 250, 750, 1250, 2000};
  int m_vol[2];
  int m_st[2];
  int m_rc[2];
  int m_ec[2];
  bit m_gq;

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  function automatic int slow_div(input int lvl);
    if (lvl >= 94) return 1;
    if (lvl >= 54) return 2;
    if (lvl >= 26) return 4;
    if (lvl >= 14) return 8;
    if (lvl >= 6)  return 16;
    return 30;
  endfunction

  // One sample of prescaling; returns 1 when the level should move.
  function automatic bit advance(input int k, input int idx, input int dv);
    if (m_rc[k] + 1 >= period_tab[idx]) begin
      m_rc[k] = 0;
      if (m_ec[k] + 1 >= dv) begin
        m_ec[k] = 0;
        return 1'b1;
      end
      m_ec[k] = m_ec[k] + 1;
      return 1'b0;
    end
    m_rc[k] = m_rc[k] + 1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_vol[k] = 0; m_st[k] = S_IDLE; m_rc[k] = 0; m_ec[k] = 0;
    end
    m_gq = 1'b0;
  endtask

  task automatic model_strobe();
    bit rise;
    bit fall;
    int tgt;
    int dv;
    rise = gate && !m_gq;
    fall = !gate && m_gq;
    tgt  = int'(sustain) * 17;
    for (int k = 0; k < 2; k++) begin
      dv = (k == 1) ? slow_div(m_vol[k]) : 1;
      if (rise || fall) begin
        m_st[k] = rise ? S_ATK : S_REL;
        m_rc[k] = 0; m_ec[k] = 0;
      end else begin
        case (m_st[k])
          S_ATK: if (advance(k, int'(attack), 1)) begin
            m_vol[k] = (m_vol[k] < 255) ? m_vol[k] + 1 : 255;
            if (m_vol[k] == 255) m_st[k] = S_DEC;
          end
          S_DEC: begin
            if (m_vol[k] <= tgt) begin
              m_st[k] = S_SUS; m_rc[k] = 0; m_ec[k] = 0;
            end else if (advance(k, int'(decay), dv)) begin
              m_vol[k] = m_vol[k] - 1;
              if (m_vol[k] == tgt) m_st[k] = S_SUS;
            end
          end
          S_SUS: begin
            m_rc[k] = 0; m_ec[k] = 0;
            if (tgt < m_vol[k]) m_st[k] = S_DEC;
          end
          S_REL: begin
            if (m_vol[k] == 0) begin
              m_st[k] = S_IDLE; m_rc[k] = 0; m_ec[k] = 0;
            end else if (advance(k, int'(release_rate), dv)) begin
              m_vol[k] = m_vol[k] - 1;
              if (m_vol[k] == 0) m_st[k] = S_IDLE;
            end
          end
          default: begin
            m_vol[k] = 0; m_rc[k] = 0; m_ec[k] = 0;
          end
        endcase
      end
    end
    m_gq = gate;
  endtask

  // scoreboard comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_checks++;
    assert (obs === req) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, req);
    end
  endtask

  task automatic check_all(input string where);
    chk({where, "_vol_exp"},   32'(e1.env_vol),   32'(m_vol[1]));
    chk({where, "_state_exp"}, 32'(e1.env_state), 32'(m_st[1]));
    chk({where, "_idle_exp"},  32'(e1.env_idle),  32'(m_st[1] == S_IDLE));
    chk({where, "_vol_lin"},   32'(e0.env_vol),   32'(m_vol[0]));
    chk({where, "_state_lin"}, 32'(e0.env_state), 32'(m_st[0]));
    chk({where, "_idle_lin"},  32'(e0.env_idle),  32'(m_st[0] == S_IDLE));
  endtask

  // driver tasks
  task automatic do_strobe();
    @(negedge clk);
    sample_strobe = 1'b1;
    @(negedge clk);
    sample_strobe = 1'b0;
    model_strobe();
    check_all("strobe");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sample_strobe = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    sample_strobe = 1'b0;
    model_reset();
    check_all("reset");
  endtask

  // Toggle controls on clocks without a strobe; nothing may move.
  task automatic idle_wiggle(input int n);
    logic       g;
    logic [3:0] s;
    logic [3:0] a;
    g = gate; s = sustain; a = attack;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      gate    = 1'($urandom_range(0, 1));
      sustain = 4'($urandom_range(0, 15));
      attack  = 4'($urandom_range(0, 15));
      check_all("no_strobe");
    end
    @(negedge clk);
    gate = g; sustain = s; attack = a;
    check_all("no_strobe");
  endtask

  initial begin
    int guard;

    do_reset();
    chk("reset_vol", 32'(e1.env_vol), 32'h0);
    chk("reset_state", 32'(e1.env_state), 32'd0);
    chk("reset_idle", 32'(e1.env_idle), 32'd1);

    // full attack then decay to S=8
    gate = 1'b1; attack = 4'd0; decay = 4'd0; sustain = 4'd8; release_rate = 4'd0;
    do_strobe();
    chk("edge_state", 32'(e1.env_state), 32'd1);
    chk("edge_vol", 32'(e1.env_vol), 32'h0);
    do_strobe();
    chk("attack_first", 32'(e1.env_vol), 32'h01);
    repeat (254) do_strobe();
    chk("attack_peak", 32'(e1.env_vol), 32'hFF);
    chk("peak_decay", 32'(e1.env_state), 32'd2);
    repeat (118) do_strobe();
    chk("decay_118", 32'(e1.env_vol), 32'h89);
    do_strobe();
    chk("sustain_vol", 32'(e1.env_vol), 32'h88);
    chk("sustain_state", 32'(e1.env_state), 32'd3);
    idle_wiggle(5);

    // park in SUSTAIN at 0x80 by lowering then raising the target
    sustain = 4'd7;
    do_strobe();
    chk("redecay_state", 32'(e1.env_state), 32'd2);
    repeat (8) do_strobe();
    chk("at_80", 32'(e1.env_vol), 32'h80);
    sustain = 4'd8;
    do_strobe();
    chk("hold_80_state", 32'(e1.env_state), 32'd3);
    chk("hold_80_vol", 32'(e1.env_vol), 32'h80);

    // release timing: 601 strobes exponential, 128 linear
    gate = 1'b0;
    do_strobe();
    chk("rel_state", 32'(e1.env_state), 32'd4);
    for (int i = 1; i <= 601; i++) begin
      do_strobe();
      if (i == 127) chk("lin_127_vol", 32'(e0.env_vol), 32'h01);
      if (i == 128) begin
        chk("lin_128_vol", 32'(e0.env_vol), 32'h00);
        chk("lin_128_idle", 32'(e0.env_idle), 32'd1);
      end
      if (i == 600) begin
        chk("exp_600_vol", 32'(e1.env_vol), 32'h01);
        chk("exp_600_state", 32'(e1.env_state), 32'd4);
      end
      if (i == 601) begin
        chk("exp_601_vol", 32'(e1.env_vol), 32'h00);
        chk("exp_601_idle", 32'(e1.env_idle), 32'd1);
      end
    end

    // attack period 4, then rate change mid-count
    attack = 4'd2; gate = 1'b1;
    do_strobe();
    for (int i = 1; i <= 9; i++) begin
      do_strobe();
      if (i == 3) chk("a4_s3", 32'(e1.env_vol), 32'h00);
      if (i == 4) chk("a4_s4", 32'(e1.env_vol), 32'h01);
      if (i == 7) chk("a4_s7", 32'(e1.env_vol), 32'h01);
      if (i == 8) chk("a4_s8", 32'(e1.env_vol), 32'h02);
    end
    attack = 4'd0;
    do_strobe();
    chk("rate_change_step", 32'(e1.env_vol), 32'h03);

    // re-trigger during release at 0x40
    guard = 0;
    while (m_vol[1] < 8'h50 && guard < 400) begin do_strobe(); guard++; end
    chk("reach_50", 32'(e1.env_vol), 32'h50);
    gate = 1'b0;
    do_strobe();
    guard = 0;
    while (m_vol[1] != 8'h40 && guard < 200) begin do_strobe(); guard++; end
    chk("rel_at_40", 32'(e1.env_vol), 32'h40);
    gate = 1'b1;
    do_strobe();
    chk("retrig_state", 32'(e1.env_state), 32'd1);
    chk("retrig_vol", 32'(e1.env_vol), 32'h40);
    do_strobe();
    chk("retrig_41", 32'(e1.env_vol), 32'h41);
    do_strobe();
    chk("retrig_42", 32'(e1.env_vol), 32'h42);

    // S=F: immediate sustain at 0xFF, then lower/raise target
    sustain = 4'hF;
    guard = 0;
    while (m_st[1] != S_DEC && guard < 300) begin do_strobe(); guard++; end
    chk("sf_peak", 32'(e1.env_vol), 32'hFF);
    do_strobe();
    chk("sf_sustain", 32'(e1.env_state), 32'd3);
    sustain = 4'd4;
    do_strobe();
    chk("s4_redecay", 32'(e1.env_state), 32'd2);
    guard = 0;
    while (m_st[1] != S_SUS && guard < 2000) begin do_strobe(); guard++; end
    chk("s4_level", 32'(e1.env_vol), 32'h44);
    chk("s4_state", 32'(e1.env_state), 32'd3);
    sustain = 4'hF;
    repeat (5) do_strobe();
    chk("sf_hold_vol", 32'(e1.env_vol), 32'h44);
    chk("sf_hold_state", 32'(e1.env_state), 32'd3);

    // reset mid-attack with gate held high
    gate = 1'b0;
    do_strobe();
    gate = 1'b1; attack = 4'd5;
    repeat (30) do_strobe();
    do_reset();
    chk("rst_mid_vol", 32'(e1.env_vol), 32'h00);
    chk("rst_mid_idle", 32'(e1.env_idle), 32'd1);
    do_strobe();
    chk("rst_gate_high", 32'(e1.env_state), 32'd1);

    // randomized stimulus against the model
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 39) == 0) gate = ~gate;
      if ($urandom_range(0, 15) == 0) attack = 4'($urandom_range(0, 4));
      if ($urandom_range(0, 15) == 0) decay = 4'($urandom_range(0, 5));
      if ($urandom_range(0, 15) == 0) release_rate = 4'($urandom_range(0, 5));
      if ($urandom_range(0, 29) == 0) sustain = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) idle_wiggle(int'($urandom_range(1, 3)));
      if ($urandom_range(0, 799) == 0) do_reset();
      do_strobe();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
